// File: rtl/y86_mem_master.sv
// ---------------------------------------------------------------------------
// y86_mem_master
//
// Memory-stage bus master for the Y86 pipeline. Decodes icode/valA/valE/valP
// into at most one read or write on the data-memory req/ack bus, stalls the
// pipeline while the access is outstanding, returns read data in valM and
// flags out-of-range addresses and unresponsive memory.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start              memory stage holds a valid instruction (used in IDLE)
//   icode              instruction code
//   valA, valE, valP   operand / address / next-PC values from execute
//   stall              high while a transaction is outstanding
//   done               one-cycle pulse when the stage access completes
//   error              one-cycle pulse with done: bad address or timeout
//   valM               last read data
//   mem_req            request, held until ack or abort
//   mem_we             1 = write, 0 = read
//   mem_addr           word address
//   mem_wdata          write data
//   mem_ack            memory completed the transaction this cycle
//   mem_rdata          read data, valid with mem_ack on reads
// ---------------------------------------------------------------------------
module y86_mem_master #(
    parameter int MEM_WORDS = 128,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        stall,
    output logic        done,
    output logic        error,
    output logic [63:0] valM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [CW-1:0] count, count_next;

    logic        is_read, is_write;
    logic [63:0] acc_addr, acc_data;

    logic        req_next, we_next, done_next, error_next;
    logic [63:0] addr_next, wdata_next, valm_next;

    // Instruction decode: which icodes touch memory, and which operand
    // supplies the address and write data.
    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        acc_addr = valE;
        acc_data = valA;
        case (icode)
            4'h5: is_read = 1'b1;
            4'h9, 4'hB: begin
                is_read  = 1'b1;
                acc_addr = valA;
            end
            4'h4, 4'hA: is_write = 1'b1;
            4'h8: begin
                is_write = 1'b1;
                acc_data = valP;
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic. Bus fields hold their value unless
    // a new access is launched; done/error default low so they only pulse.
    // An ack on the final allowed cycle takes priority over the timeout.
    always_comb begin
        state_next = state;
        count_next = count;
        req_next   = mem_req;
        we_next    = mem_we;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        valm_next  = valM;
        done_next  = 1'b0;
        error_next = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_read || is_write) begin
                        if (acc_addr < 64'(MEM_WORDS)) begin
                            req_next   = 1'b1;
                            we_next    = is_write;
                            addr_next  = acc_addr;
                            wdata_next = acc_data;
                            count_next = '0;
                            state_next = BUSY;
                        end else begin
                            done_next  = 1'b1;
                            error_next = 1'b1;
                        end
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    req_next   = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                    if (!mem_we) begin
                        valm_next = mem_rdata;
                    end
                end else if (count == CW'(TIMEOUT - 1)) begin
                    req_next   = 1'b0;
                    done_next  = 1'b1;
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'd0;
            mem_wdata <= 64'd0;
            valM      <= 64'd0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            mem_req   <= req_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            valM      <= valm_next;
            done      <= done_next;
            error     <= error_next;
        end
    end

    assign stall = (state == BUSY);

endmodule

// File: tb/tb_y86_mem_master.sv
// ---------------------------------------------------------------------------
// tb_y86_mem_master
//
// Directed testbench for y86_mem_master. Each task drives one scenario and
// checks the outputs against hand-computed values one step after each
// rising clock edge; the memory side is played directly by the tasks.
// ---------------------------------------------------------------------------
module tb_y86_mem_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valA = 64'd0;
    logic [63:0] valE = 64'd0;
    logic [63:0] valP = 64'd0;
    logic        stall, done, error;
    logic [63:0] valM;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    int tests = 0;
    int fails = 0;

    y86_mem_master #(.MEM_WORDS(128), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .icode     (icode),
        .valA      (valA),
        .valE      (valE),
        .valP      (valP),
        .stall     (stall),
        .done      (done),
        .error     (error),
        .valM      (valM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests++;
        if ({stall, done, error, mem_req, mem_we} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reset_flags got %b want 00000", {stall, done, error, mem_req, mem_we});
        end
        tests++;
        if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || valM !== 64'd0) begin
            fails++;
            $display("[TB] FAIL reset_data got addr=%h wdata=%h valM=%h want 0", mem_addr, mem_wdata, valM);
        end
    endtask

    task automatic test_rmmovq();
        start = 1'b1; icode = 4'h4; valE = 64'd5; valA = 64'hDEAD; valP = 64'h77;
        tick();
        start = 1'b0;
        tests++;
        if ({mem_req, mem_we, stall, done} !== 4'b1110 || mem_addr !== 64'd5 || mem_wdata !== 64'hDEAD) begin
            fails++;
            $display("[TB] FAIL rmmovq_req got req/we/stall/done=%b addr=%h wdata=%h want 1110 5 dead",
                     {mem_req, mem_we, stall, done}, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests++;
        if ({mem_req, stall, done, error} !== 4'b0010) begin
            fails++;
            $display("[TB] FAIL rmmovq_done got req/stall/done/err=%b want 0010", {mem_req, stall, done, error});
        end
        tick();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rmmovq_pulse got done=%b want 0", done);
        end
    endtask

    task automatic test_mrmovq_wait();
        int reqs = 0;
        int stalls = 0;
        start = 1'b1; icode = 4'h5; valE = 64'd5; valA = 64'd9;
        tick();
        start = 1'b0;
        tests++;
        if (mem_we !== 1'b0 || mem_addr !== 64'd5) begin
            fails++;
            $display("[TB] FAIL mrmovq_req got we=%b addr=%h want 0 5", mem_we, mem_addr);
        end
        for (int c = 1; c <= 3; c++) begin
            if (mem_req) reqs++;
            if (stall) stalls++;
            if (c == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 64'hDEAD;
            end
            tick();
        end
        mem_ack = 1'b0;
        tests++;
        if (reqs != 3 || stalls != 3) begin
            fails++;
            $display("[TB] FAIL mrmovq_wait got req=%0d stall=%0d cycles want 3 3", reqs, stalls);
        end
        tests++;
        if ({mem_req, done, error} !== 3'b010 || valM !== 64'hDEAD) begin
            fails++;
            $display("[TB] FAIL mrmovq_done got req/done/err=%b valM=%h want 010 dead", {mem_req, done, error}, valM);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start = 1'b1; icode = 4'h8; valE = 64'd120; valP = 64'h40; valA = 64'h99;
        tick();
        start = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'd120 || mem_wdata !== 64'h40) begin
            fails++;
            $display("[TB] FAIL call_req got req=%b we=%b addr=%h wdata=%h want 1 1 78 40",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tests++;
        if (done !== 1'b1 || mem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL call_done got done=%b req=%b want 1 0", done, mem_req);
        end
        start = 1'b1; icode = 4'h9; valA = 64'd120; valE = 64'd3;
        tick();
        start = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'd120 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ret_req got req=%b we=%b addr=%h done=%b want 1 0 78 0",
                     mem_req, mem_we, mem_addr, done);
        end
        mem_ack = 1'b1;
        mem_rdata = 64'h40;
        tick();
        mem_ack = 1'b0;
        tests++;
        if (done !== 1'b1 || error !== 1'b0 || valM !== 64'h40) begin
            fails++;
            $display("[TB] FAIL ret_done got done=%b err=%b valM=%h want 1 0 40", done, error, valM);
        end
        tick();
    endtask

    task automatic test_range();
        start = 1'b1; icode = 4'hA; valE = 64'd128; valA = 64'h11;
        tick();
        start = 1'b0;
        tests++;
        if ({mem_req, stall, done, error} !== 4'b0011) begin
            fails++;
            $display("[TB] FAIL range_128 got req/stall/done/err=%b want 0011", {mem_req, stall, done, error});
        end
        tick();
        start = 1'b1; icode = 4'h5; valE = 64'h8000_0000_0000_0005;
        tick();
        start = 1'b0;
        tests++;
        if ({mem_req, done, error} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL range_high got req/done/err=%b want 011", {mem_req, done, error});
        end
        tick();
        start = 1'b1; icode = 4'hA; valE = 64'd127; valA = 64'h22;
        tick();
        start = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 64'd127 || mem_wdata !== 64'h22 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL range_127 got req=%b addr=%h wdata=%h done=%b want 1 7f 22 0",
                     mem_req, mem_addr, mem_wdata, done);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        start = 1'b1; icode = 4'h6; valE = 64'd500;
        tick();
        start = 1'b0;
        tests++;
        if ({mem_req, done, error} !== 3'b010 || valM !== 64'h40) begin
            fails++;
            $display("[TB] FAIL noaccess got req/done/err=%b valM=%h want 010 40", {mem_req, done, error}, valM);
        end
        tick();
    endtask

    task automatic test_timeout();
        int reqs = 0;
        start = 1'b1; icode = 4'hB; valA = 64'd3; valE = 64'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            reqs++;
            tick();
        end
        tests++;
        if (reqs != 16) begin
            fails++;
            $display("[TB] FAIL timeout_len got %0d req cycles want 16", reqs);
        end
        tests++;
        if ({done, error} !== 2'b11 || valM !== 64'h40) begin
            fails++;
            $display("[TB] FAIL timeout_done got done/err=%b valM=%h want 11 40", {done, error}, valM);
        end
        tick();
        reqs = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (mem_req) reqs++;
            if (c == 16) begin
                mem_ack = 1'b1;
                mem_rdata = 64'h1234;
            end
            tick();
        end
        mem_ack = 1'b0;
        tests++;
        if (reqs != 16 || {mem_req, done, error} !== 3'b010 || valM !== 64'h1234) begin
            fails++;
            $display("[TB] FAIL ack_at_limit got reqs=%0d req/done/err=%b valM=%h want 16 010 1234",
                     reqs, {mem_req, done, error}, valM);
        end
        tick();
    endtask

    task automatic test_reset_busy();
        start = 1'b1; icode = 4'h5; valE = 64'd7;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({mem_req, stall, done, error} !== 4'b0000 || valM !== 64'd0) begin
            fails++;
            $display("[TB] FAIL reset_busy got req/stall/done/err=%b valM=%h want 0000 0",
                     {mem_req, stall, done, error}, valM);
        end
        mem_ack = 1'b1;
        mem_rdata = 64'hBAD;
        tick();
        mem_ack = 1'b0;
        tests++;
        if ({mem_req, stall, done} !== 3'b000 || valM !== 64'd0) begin
            fails++;
            $display("[TB] FAIL late_ack got req/stall/done=%b valM=%h want 000 0", {mem_req, stall, done}, valM);
        end
    endtask

    initial begin
        test_reset();
        test_rmmovq();
        test_mrmovq_wait();
        test_back_to_back();
        test_range();
        test_timeout();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/y86_mem_master.md
# y86_mem_master

Memory-stage bus master for the Y86 pipeline: decodes the stage's icode/valA/valE/valP into a single read or write transaction and drives it to the data memory over a req/ack handshake that tolerates variable memory latency. It stalls the pipeline while a transaction is outstanding. It returns valM for loads/ret/popq. It flags an error for an out-of-range address or a memory that never acknowledges. The block sits between the execute/memory pipeline register and the data memory.

## Interface
- MEM_WORDS, 128, number of 64-bit words in data memory; valid word addresses are 0..MEM_WORDS-1.
- TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ack before abort (>=1).
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  memory stage holds a valid instruction; sampled only in IDLE.
- icode  input  4  instruction code.
- valA, valE, valP  input  64 each  operand/address/next-PC values from execute.
- stall  output  1  high while a transaction is outstanding (state BUSY).
- done  output  1  one-cycle pulse: stage access complete.
- error  output  1  one-cycle pulse coincident with done: address out of range or timeout.
- valM  output  64  read data; holds last read value.
- mem_req  output  1  transaction request; held until ack or abort.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  64  word address; stable while mem_req.
- mem_wdata  output  64  write data; stable while mem_req.
- mem_ack  input  1  memory completed transaction this cycle.
- mem_rdata  input  64  read data, valid when mem_ack=1 and mem_we=0.

## Operation
- Decode: read for icode 5 (mrmovq, addr valE), 9 (ret, addr valA), B (popq, addr valA). Write for 4 (rmmovq, addr valE, data valA), A (pushq, addr valE, data valA), 8 (call, addr valE, data valP). All other icodes are no-access.
- States: IDLE, BUSY.
- IDLE, start=1, memory icode, addr < MEM_WORDS (unsigned 64-bit compare): latch addr/we/wdata, mem_req<=1, clear counter, go BUSY.
- IDLE, start=1, memory icode, addr >= MEM_WORDS: no request; done<=1, error<=1; stay IDLE.
- IDLE, start=1, non-memory icode: no request; done<=1, error<=0; valM unchanged.
- BUSY, mem_ack=1: mem_req<=0. If read, valM<=mem_rdata. done<=1; go IDLE.
- BUSY, mem_ack=0, counter==TIMEOUT-1: mem_req<=0, done<=1, error<=1; valM unchanged; go IDLE.
- BUSY, otherwise: counter+1; mem_req/addr/we/wdata held.
- start, icode and val* are ignored in BUSY. Upstream holds them while stall=1.
- mem_ack in IDLE is ignored.

## Timing
- Reset values: IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, valM=0, done=0, error=0, counter=0, stall=0.
- Reset mid-transaction: mem_req drops the cycle after reset. No done is produced for the aborted access.
- stall = (state==BUSY), registered via state.
- Minimum memory access latency: start sampled at edge T0. mem_req is high in cycle T0..T1. mem_ack=1 sampled at T1. done is high in cycle T1..T2. Total 2 cycles.
- No-access and range-error paths: done in the cycle after the start edge (1 cycle).
- mem_req is high for exactly TIMEOUT cycles before a timeout abort.
- ack and timeout at the same edge: ack wins, error=0.
- Back-to-back: start in IDLE is accepted in the same cycle done is high. Throughput is one access per 2 cycles with 0-wait memory.
- done/error are high exactly one cycle per accepted start.

## Test plan
- rmmovq: icode=4, valE=5, valA=0xDEAD, memory acks 1 cycle after req -> mem_req=1, mem_we=1, mem_addr=5, mem_wdata=0xDEAD for 1 cycle; done pulse; stall high 1 cycle.
- mrmovq, 3-cycle wait: icode=5, valE=5, mem_rdata=0xDEAD with ack on 3rd req cycle -> req held 3 cycles, stall high 3 cycles, valM=0xDEAD after done, error=0.
- call then ret back-to-back: icode=8, valE=120, valP=0x40; then icode=9, valA=120 -> write 0x40 to 120, then read returns 0x40 into valM; second req asserts the cycle after first done.
- Range/no-access: pushq valE=128 -> no mem_req, done=1 and error=1 next cycle. icode=6 -> done=1, error=0, valM unchanged.
- Timeout: TIMEOUT=16, popq valA=3, ack never -> mem_req high exactly 16 cycles, then done=1, error=1, valM unchanged. Repeat with ack on 16th cycle -> error=0.
- Reset in BUSY on the 2nd wait cycle -> mem_req=0, stall=0 next cycle; no done; a late ack is ignored.
